// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : General-purpose register file with two prioritised write
//                ports, NUM_RD combinational read ports with optional
//                same-cycle write forwarding, and a per-register pending
//                (scoreboard) bit with a registered population count.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_pending,
    input  logic                       wa_we,
    input  logic [ADDR_W-1:0]          wa_addr,
    input  logic [DATA_W-1:0]          wa_data,
    input  logic                       wb_we,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       iss_valid,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic [ADDR_W:0]            pend_cnt
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]  r_regs [c_DEPTH];
    logic [c_DEPTH-1:0] r_pend;
    logic [ADDR_W:0]    r_pend_cnt;

    logic [c_DEPTH-1:0] w_pend_next;
    logic [ADDR_W:0]    w_pend_cnt_next;
    logic               w_wa_ok;
    logic               w_wb_ok;
    logic               w_fwd_en;

    // Register 0 is hard-wired, so writes aimed at it are simply discarded.
    assign w_wa_ok  = wa_we && (wa_addr != '0);
    assign w_wb_ok  = wb_we && (wb_addr != '0);
    // Forwarding is suppressed during reset so reads never expose data
    // that the reset is about to discard.
    assign w_fwd_en = (BYPASS != 0) && !reset;

    // Storage update: port B first, port A second so A wins on a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < c_DEPTH; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            if (w_wb_ok) begin
                r_regs[wb_addr] <= wb_data;
            end
            if (w_wa_ok) begin
                r_regs[wa_addr] <= wa_data;
            end
        end
    end

    // Next pending vector: a new issue outranks a same-cycle writeback.
    always_comb begin
        w_pend_next = r_pend;
        for (int k = 1; k < c_DEPTH; k++) begin
            if (iss_valid && (iss_addr == ADDR_W'(k))) begin
                w_pend_next[k] = 1'b1;
            end else if ((w_wa_ok && (wa_addr == ADDR_W'(k))) ||
                         (w_wb_ok && (wb_addr == ADDR_W'(k)))) begin
                w_pend_next[k] = 1'b0;
            end
        end
        w_pend_next[0] = 1'b0;
    end

    // Population count of the next pending vector, registered alongside it.
    always_comb begin
        w_pend_cnt_next = '0;
        for (int k = 0; k < c_DEPTH; k++) begin
            w_pend_cnt_next = w_pend_cnt_next + {{ADDR_W{1'b0}}, w_pend_next[k]};
        end
    end

    // Scoreboard state and its count share one edge so they never disagree.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend     <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_pend     <= w_pend_next;
            r_pend_cnt <= w_pend_cnt_next;
        end
    end

    assign pend_cnt = r_pend_cnt;

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_hit_a;
        logic              w_hit_b;

        assign w_addr  = rd_addr[gi*ADDR_W +: ADDR_W];
        assign w_hit_a = w_fwd_en && w_wa_ok && (wa_addr == w_addr);
        assign w_hit_b = w_fwd_en && w_wb_ok && (wb_addr == w_addr);

        // Read mux: r0 constant, then port A forward, port B forward, array.
        assign rd_data[gi*DATA_W +: DATA_W] =
            (w_addr == '0) ? '0      :
            w_hit_a        ? wa_data :
            w_hit_b        ? wb_data :
                             r_regs[w_addr];

        // A forwarded writeback already satisfies the consumer this cycle.
        assign rd_pending[gi] = r_pend[w_addr] & ~(w_hit_a | w_hit_b);
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_scoreboard
//  Description : Self-checking bench for regfile_scoreboard. Two instances
//                (forwarding on / off) share stimulus; an array-based model
//                predicts read data, pending flags and the pending count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic [NR*AW-1:0] rd_addr;
    logic           wa_we, wb_we, iss_valid;
    logic [AW-1:0]  wa_addr, wb_addr, iss_addr;
    logic [DW-1:0]  wa_data, wb_data;

    logic [NR*DW-1:0] rd_data_b, rd_data_n;
    logic [NR-1:0]    rd_pend_b, rd_pend_n;
    logic [AW:0]      pend_cnt_b, pend_cnt_n;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [DW-1:0] m_reg  [DEPTH];
    bit            m_pend [DEPTH];

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_pending(rd_pend_b), .wa_we(wa_we), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .pend_cnt(pend_cnt_b)
    );

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .rd_pending(rd_pend_n), .wa_we(wa_we), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .pend_cnt(pend_cnt_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && !reset && wa_we && wa_addr == a) return wa_data;
        if (byp && !reset && wb_we && wb_addr == a) return wb_data;
        return m_reg[a];
    endfunction

    function automatic bit exp_pend(input logic [AW-1:0] a, input bit byp);
        bit wr;
        if (a == 0) return 1'b0;
        wr = (wa_we && wa_addr == a) || (wb_we && wb_addr == a);
        return m_pend[a] && !(byp && !reset && wr);
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int k = 0; k < DEPTH; k++) c += int'(m_pend[k]);
        return c;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) begin
            m_reg[k]  = '0;
            m_pend[k] = 1'b0;
        end
    endtask

    // Apply the behaviour rules for one rising edge to the model.
    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else begin
            if (wb_we && wb_addr != 0) m_reg[wb_addr] = wb_data;
            if (wa_we && wa_addr != 0) m_reg[wa_addr] = wa_data;
            if (wb_we && wb_addr != 0) m_pend[wb_addr] = 1'b0;
            if (wa_we && wa_addr != 0) m_pend[wa_addr] = 1'b0;
            if (iss_valid && iss_addr != 0) m_pend[iss_addr] = 1'b1;
        end
    endtask

    task automatic idle_inputs();
        reset = 0; wa_we = 0; wb_we = 0; iss_valid = 0;
        wa_addr = '0; wb_addr = '0; iss_addr = '0;
        wa_data = '0; wb_data = '0; rd_addr = '0;
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic settle_check();
        logic [AW-1:0] a;
        #1;
        for (int i = 0; i < NR; i++) begin
            a = rd_addr[i*AW +: AW];
            check($sformatf("rd_data_byp[%0d] a=%0d", i, a), rd_data_b[i*DW +: DW], exp_data(a, 1'b1));
            check($sformatf("rd_data_nobyp[%0d] a=%0d", i, a), rd_data_n[i*DW +: DW], exp_data(a, 1'b0));
            check($sformatf("rd_pend_byp[%0d] a=%0d", i, a), 32'(rd_pend_b[i]), 32'(exp_pend(a, 1'b1)));
            check($sformatf("rd_pend_nobyp[%0d] a=%0d", i, a), 32'(rd_pend_n[i]), 32'(exp_pend(a, 1'b0)));
        end
    endtask

    task automatic clock_check();
        @(posedge clk);
        model_edge();
        #1;
        check("pend_cnt_byp", 32'(pend_cnt_b), 32'(model_count()));
        check("pend_cnt_nobyp", 32'(pend_cnt_n), 32'(model_count()));
        @(negedge clk);
    endtask

    task automatic cycle();
        settle_check();
        clock_check();
    endtask

    initial begin
        model_reset();
        idle_inputs();
        reset = 1;
        @(negedge clk);
        cycle();
        reset = 0;

        // 1: every register reads zero and idle after reset
        for (int r = 0; r < DEPTH; r++) begin
            idle_inputs();
            rd_addr = {AW'(DEPTH-1-r), AW'(r)};
            cycle();
        end
        check("reset_pend_cnt", 32'(pend_cnt_b), 32'd0);

        // 2: forwarding of a same-cycle write
        idle_inputs();
        wa_we = 1; wa_addr = 5; wa_data = 32'hDEADBEEF; rd_addr = {AW'(0), AW'(5)};
        settle_check();
        check("byp_same_cycle_r5", rd_data_b[31:0], 32'hDEADBEEF);
        check("nobyp_same_cycle_r5", rd_data_n[31:0], 32'h0);
        clock_check();
        idle_inputs(); rd_addr = {AW'(0), AW'(5)};
        settle_check();
        check("nobyp_next_cycle_r5", rd_data_n[31:0], 32'hDEADBEEF);
        clock_check();

        // 3: port collision and r0 write
        idle_inputs();
        wa_we = 1; wa_addr = 7; wa_data = 32'h11;
        wb_we = 1; wb_addr = 7; wb_data = 32'h22;
        cycle();
        idle_inputs();
        wa_we = 1; wa_addr = 0; wa_data = 32'hFFFF; rd_addr = {AW'(0), AW'(7)};
        settle_check();
        check("collision_r7", rd_data_n[31:0], 32'h11);
        check("r0_write_ignored", rd_data_b[63:32], 32'h0);
        clock_check();

        // 4: issue then writeback clears pending
        idle_inputs(); iss_valid = 1; iss_addr = 3;
        cycle();
        check("issue_r3_cnt", 32'(pend_cnt_b), 32'd1);
        idle_inputs(); rd_addr = {AW'(0), AW'(3)};
        settle_check();
        check("issue_r3_pending", 32'(rd_pend_b[0]), 32'd1);
        clock_check();
        idle_inputs(); wb_we = 1; wb_addr = 3; wb_data = 32'h5; rd_addr = {AW'(0), AW'(3)};
        settle_check();
        check("wb_r3_pend_cleared", 32'(rd_pend_b[0]), 32'd0);
        check("wb_r3_data", rd_data_b[31:0], 32'h5);
        clock_check();
        check("wb_r3_cnt_zero", 32'(pend_cnt_b), 32'd0);

        // 5: issue and write to the same register in one cycle
        idle_inputs(); iss_valid = 1; iss_addr = 3; wa_we = 1; wa_addr = 3; wa_data = 32'h77;
        cycle();
        idle_inputs(); rd_addr = {AW'(3), AW'(3)};
        settle_check();
        check("iss_wr_r3_data", rd_data_n[31:0], 32'h77);
        check("iss_wr_r3_pending", 32'(rd_pend_b[1]), 32'd1);
        clock_check();

        // 6: reset overrides issue state and a same-cycle write
        for (int r = 1; r <= 4; r++) begin
            idle_inputs(); iss_valid = 1; iss_addr = AW'(r);
            cycle();
        end
        check("four_pending_cnt", 32'(pend_cnt_b), 32'd4);
        idle_inputs(); reset = 1; wa_we = 1; wa_addr = 2; wa_data = 32'h9; rd_addr = {AW'(3), AW'(2)};
        cycle();
        check("reset_cnt_zero", 32'(pend_cnt_b), 32'd0);
        idle_inputs(); rd_addr = {AW'(3), AW'(2)};
        settle_check();
        check("reset_r2_zero", rd_data_b[31:0], 32'h0);
        clock_check();

        // Randomised traffic, addresses often folded into a small window to
        // provoke collisions between ports, issues and reads.
        for (int n = 0; n < 600; n++) begin
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            idle_inputs();
            reset     = ($urandom_range(0, 63) == 0);
            wa_we     = ($urandom_range(0, 2) != 0);
            wb_we     = ($urandom_range(0, 2) != 0);
            iss_valid = ($urandom_range(0, 1) == 1);
            wa_addr   = narrow ? AW'($urandom_range(0, 5)) : AW'($urandom);
            wb_addr   = narrow ? AW'($urandom_range(0, 5)) : AW'($urandom);
            iss_addr  = narrow ? AW'($urandom_range(0, 5)) : AW'($urandom);
            wa_data   = $urandom;
            wb_data   = $urandom;
            rd_addr   = narrow ? {AW'($urandom_range(0, 5)), AW'($urandom_range(0, 5))}
                               : NR*AW'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
